// File: rtl/adder_pkg.sv
// Shared types and helpers for the iterative add/subtract unit.
package adder_pkg;

   // Sequencer states of the iterative adder.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_t;

   // Counter width for n slices; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// One CHUNK-bit ripple slice: {cout, sum} = a + b + cin.
module adder_chunk #(
   parameter int unsigned CHUNK = 4
) (
   input  logic             cin,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             cout,
   output logic [CHUNK-1:0] sum
);

   // Slice sum is CHUNK+1 bits wide so the carry falls out of the top bit.
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_iter.sv
// Iterative add/subtract: one CHUNK-bit slice per clock, LSB slice first,
// with valid/ready handshakes on request and result sides.
module adder_iter
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CNT_W  = cnt_width(NCHUNK);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;       // already inverted for subtract
   logic               r_c;       // running carry between slices
   logic [CNT_W-1:0]   r_idx;
   logic [WIDTH-1:0]   r_out;
   logic               r_carry;
   logic               r_overflow;
   logic               r_zero;

   logic [CHUNK-1:0]   w_a_slice;
   logic [CHUNK-1:0]   w_b_slice;
   logic [CHUNK-1:0]   w_sum;
   logic               w_cout;
   logic [WIDTH-1:0]   w_new_out;

   // Select the operand slice addressed by the counter and merge its sum into the result.
   always_comb begin
      w_a_slice = r_a[r_idx*CHUNK +: CHUNK];
      w_b_slice = r_b[r_idx*CHUNK +: CHUNK];
      w_new_out = r_out;
      w_new_out[r_idx*CHUNK +: CHUNK] = w_sum;
   end

   adder_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .cin  (r_c),
      .a    (w_a_slice),
      .b    (w_b_slice),
      .cout (w_cout),
      .sum  (w_sum)
   );

   // Sequencer: accept, ripple one slice per cycle, hold result until taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_a        <= '0;
         r_b        <= '0;
         r_c        <= 1'b0;
         r_idx      <= '0;
         r_out      <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_zero     <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_a     <= a;
                  // a - b - cin == a + ~b + (1 - cin)
                  r_b     <= sub ? ~b : b;
                  r_c     <= cin ^ sub;
                  r_idx   <= '0;
                  r_state <= StBusy;
               end
            end
            StBusy: begin
               r_out <= w_new_out;
               r_c   <= w_cout;
               if (r_idx == LAST_IDX) begin
                  r_carry    <= w_cout;
                  r_overflow <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                (w_sum[CHUNK-1] != r_a[WIDTH-1]);
                  r_zero     <= (w_new_out == '0);
                  r_idx      <= '0;
                  r_state    <= StDone;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign in_ready  = (r_state == StIdle) && !rst;
   assign out_valid = (r_state == StDone);
   assign out       = r_out;
   assign carry     = r_carry;
   assign overflow  = r_overflow;
   assign zero      = r_zero;

endmodule
